// File: rtl/hazard_tracker_pkg.sv
// Purpose: shared types and constants for the producer-side hazard tracker.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hazard_tracker_pkg;

    // Tuse encoding: this operand is not read by the instruction.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew encodings. A PC+8 or lui result is ready as soon as it enters E.
    localparam logic [1:0] TNEW_PC8  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Per-stage bookkeeping for one in-flight instruction.
    typedef struct packed {
        logic       reg_write;
        logic [4:0] a3;
        logic [1:0] tnew;
    } hz_entry_t;

    // A bubble writes nothing and has no pending result.
    localparam hz_entry_t HZ_BUBBLE = '{reg_write: 1'b0, a3: 5'd0, tnew: TNEW_PC8};

    // Count remaining latency down by one stage, holding at zero.
    function automatic logic [1:0] dec_tnew(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// Purpose: one pipeline stage of {RegWrite, A3, Tnew} bookkeeping.
// Latency: 1 cycle, d to q.
// Backpressure: none; loads every cycle, bubble input overrides the data.
// Ports: clk/reset (sync, active-high), bubble (load HZ_BUBBLE),
//        dec_en (count Tnew down while loading), d (incoming entry), q (held entry).
module hz_stage_reg
    import hazard_tracker_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      bubble,
    input  logic      dec_en,
    input  hz_entry_t d,
    output hz_entry_t q
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q <= HZ_BUBBLE;
        end else begin
            q.reg_write <= d.reg_write;
            q.a3        <= d.a3;
            q.tnew      <= dec_en ? dec_tnew(d.tnew) : d.tnew;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Purpose: track destination/Tnew of E, M, W instructions and raise stall on D-stage RAW hazards.
// Latency: stage outputs registered (1 cycle per stage); stall is combinational from D inputs.
// Backpressure: stall freezes PC/D upstream and injects a bubble into E; flush overrides stall.
// Ports: A1_D/A2_D/Tuse_*_D (D-stage operand reads), RegWrite_D/A3_D/Tnew_D (D-stage producer),
//        flush (bubble E/M/W), per-stage RegWrite/A3/Tnew outputs, stall, stall_cycles (saturating).
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       A1_D,
    input  logic [4:0]       A2_D,
    input  logic [1:0]       Tuse_rs_D,
    input  logic [1:0]       Tuse_rt_D,
    input  logic             RegWrite_D,
    input  logic [4:0]       A3_D,
    input  logic [1:0]       Tnew_D,
    input  logic             flush,
    output logic             RegWrite_E,
    output logic             RegWrite_M,
    output logic             RegWrite_W,
    output logic [4:0]       A3_E,
    output logic [4:0]       A3_M,
    output logic [4:0]       A3_W,
    output logic [1:0]       Tnew_E,
    output logic [1:0]       Tnew_M,
    output logic [1:0]       Tnew_W,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_entry_t d_ent, e_q, m_q, w_q;

    assign d_ent = '{reg_write: RegWrite_D, a3: A3_D, tnew: Tnew_D};

    // A stage blocks an operand when it will write that (non-zero) register
    // later than the D instruction needs to consume it.
    function automatic logic hz(input hz_entry_t s, input logic [4:0] a, input logic [1:0] tuse);
        return s.reg_write && (s.a3 != 5'd0) && (s.a3 == a) &&
               (tuse != TUSE_NONE) && (tuse < s.tnew);
    endfunction

    // W is never checked: a legal Tnew has always reached zero by then.
    always_comb begin
        stall = 1'b0;
        if (!reset && !flush) begin
            stall = hz(e_q, A1_D, Tuse_rs_D) | hz(e_q, A2_D, Tuse_rt_D) |
                    hz(m_q, A1_D, Tuse_rs_D) | hz(m_q, A2_D, Tuse_rt_D);
        end
    end

    hz_stage_reg u_stage_e (
        .clk    (clk),
        .reset  (reset),
        .bubble (flush | stall),
        .dec_en (1'b0),
        .d      (d_ent),
        .q      (e_q)
    );

    hz_stage_reg u_stage_m (
        .clk    (clk),
        .reset  (reset),
        .bubble (flush),
        .dec_en (1'b1),
        .d      (e_q),
        .q      (m_q)
    );

    hz_stage_reg u_stage_w (
        .clk    (clk),
        .reset  (reset),
        .bubble (flush),
        .dec_en (1'b1),
        .d      (m_q),
        .q      (w_q)
    );

    // Flush leaves the count alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign RegWrite_E = e_q.reg_write;
    assign RegWrite_M = m_q.reg_write;
    assign RegWrite_W = w_q.reg_write;
    assign A3_E       = e_q.a3;
    assign A3_M       = m_q.a3;
    assign A3_W       = w_q.a3;
    assign Tnew_E     = e_q.tnew;
    assign Tnew_M     = m_q.tnew;
    assign Tnew_W     = w_q.tnew;

endmodule

// File: tb/tb_hazard_tracker.sv
// Purpose: directed and randomized check of hazard_tracker against a ready-time reference model.
// Latency: checks registered stage outputs one cycle per stage, stall in the same cycle.
// Backpressure: the bench holds a stalled D instruction where the scenario requires it.
module tb_hazard_tracker;
    import hazard_tracker_pkg::*;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       A1_D, A2_D, A3_D;
    logic [1:0]       Tuse_rs_D, Tuse_rt_D, Tnew_D;
    logic             RegWrite_D, flush;
    logic             RegWrite_E, RegWrite_M, RegWrite_W;
    logic [4:0]       A3_E, A3_M, A3_W;
    logic [1:0]       Tnew_E, Tnew_M, Tnew_W;
    logic             stall;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_tracker #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .A1_D         (A1_D),
        .A2_D         (A2_D),
        .Tuse_rs_D    (Tuse_rs_D),
        .Tuse_rt_D    (Tuse_rt_D),
        .RegWrite_D   (RegWrite_D),
        .A3_D         (A3_D),
        .Tnew_D       (Tnew_D),
        .flush        (flush),
        .RegWrite_E   (RegWrite_E),
        .RegWrite_M   (RegWrite_M),
        .RegWrite_W   (RegWrite_W),
        .A3_E         (A3_E),
        .A3_M         (A3_M),
        .A3_W         (A3_W),
        .Tnew_E       (Tnew_E),
        .Tnew_M       (Tnew_M),
        .Tnew_W       (Tnew_W),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each in-flight writer remembers the absolute cycle at
    // which its result lands in a pipeline register.
    typedef struct {
        bit rw;
        int a3;
        int ready;
    } slot_t;

    slot_t mdl_e, mdl_m, mdl_w;
    int    cyc;
    int    cnt;

    function automatic slot_t bubble_slot();
        slot_t s;
        s.rw = 0; s.a3 = 0; s.ready = 0;
        return s;
    endfunction

    function automatic int left(slot_t s);
        return (s.ready > cyc) ? s.ready - cyc : 0;
    endfunction

    // Operand needed at cycle (cyc + tuse); hazard if the result is not ready by then.
    function automatic bit needs_wait(slot_t s, int a, int tuse);
        return s.rw && (s.a3 != 0) && (s.a3 == a) && (tuse != 3) && (cyc + tuse < s.ready);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit fl, input bit rw, input int a3, input int tn,
                         input int a1, input int tr, input int a2, input int tt);
        reset      = rst;
        flush      = fl;
        RegWrite_D = rw;
        A3_D       = 5'(a3);
        Tnew_D     = 2'(tn);
        A1_D       = 5'(a1);
        Tuse_rs_D  = 2'(tr);
        A2_D       = 5'(a2);
        Tuse_rt_D  = 2'(tt);
        #1;
    endtask

    // Compare all outputs with the model, then advance both across one edge.
    task automatic tick();
        bit    exp_stall;
        slot_t nxt;
        vectors++;
        exp_stall = !reset && !flush &&
                    (needs_wait(mdl_e, A1_D, Tuse_rs_D) || needs_wait(mdl_e, A2_D, Tuse_rt_D) ||
                     needs_wait(mdl_m, A1_D, Tuse_rs_D) || needs_wait(mdl_m, A2_D, Tuse_rt_D));
        chk("RegWrite_E", RegWrite_E, mdl_e.rw);
        chk("RegWrite_M", RegWrite_M, mdl_m.rw);
        chk("RegWrite_W", RegWrite_W, mdl_w.rw);
        chk("A3_E", A3_E, mdl_e.a3);
        chk("A3_M", A3_M, mdl_m.a3);
        chk("A3_W", A3_W, mdl_w.a3);
        chk("Tnew_E", Tnew_E, left(mdl_e));
        chk("Tnew_M", Tnew_M, left(mdl_m));
        chk("Tnew_W", Tnew_W, left(mdl_w));
        chk("stall", stall, exp_stall);
        chk("stall_cycles", stall_cycles, cnt);
        if (reset || flush) begin
            mdl_e = bubble_slot();
            mdl_m = bubble_slot();
            mdl_w = bubble_slot();
            if (reset) cnt = 0;
        end else begin
            mdl_w = mdl_m;
            mdl_m = mdl_e;
            if (exp_stall) begin
                mdl_e = bubble_slot();
            end else begin
                nxt.rw    = RegWrite_D;
                nxt.a3    = A3_D;
                nxt.ready = cyc + 1 + Tnew_D;
                mdl_e     = nxt;
            end
            if (exp_stall && cnt < CNT_MAX) cnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_reg();
        case ($urandom_range(3))
            0:       return 0;
            1:       return 8;
            2:       return 9;
            default: return $urandom_range(31);
        endcase
    endfunction

    initial begin
        int k;
        // Reset held for two edges with a live producer presented in D.
        drive(1, 0, 1, 5, TNEW_LOAD, 0, 3, 0, 3);
        @(posedge clk);
        #1;
        mdl_e = bubble_slot();
        mdl_m = bubble_slot();
        mdl_w = bubble_slot();
        cyc   = 0;
        cnt   = 0;
        chk("rst_stall", stall, 0);
        tick();
        chk("rst_RegWrite_E", RegWrite_E, 0);
        chk("rst_Tnew_E", Tnew_E, 0);
        chk("rst_cnt", stall_cycles, 0);

        // Load-use: lw $8 then addu reading $8 at Tuse 1 stalls exactly once.
        drive(0, 0, 1, 8, TNEW_LOAD, 0, 3, 0, 3);
        tick();
        drive(0, 0, 1, 10, TNEW_ALU, 8, 1, 0, 3);
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_A3_M", A3_M, 8);
        chk("lu_Tnew_M", Tnew_M, 1);
        chk("lu_RegWrite_E", RegWrite_E, 0);
        chk("lu_cnt", stall_cycles, 1);
        chk("lu_stall_clear", stall, 0);
        tick();

        // Branch after load: beq reading $9 at Tuse 0 stalls twice.
        drive(0, 0, 1, 9, TNEW_LOAD, 0, 3, 0, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 3, 9, 0);
        chk("br_stall_1", stall, 1);
        tick();
        chk("br_stall_2", stall, 1);
        tick();
        chk("br_stall_clear", stall, 0);
        tick();

        // $0 never creates a hazard.
        drive(0, 0, 1, 0, TNEW_LOAD, 0, 3, 0, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_reg_stall", stall, 0);
        tick();

        // An operand that is not read never stalls.
        drive(0, 0, 1, 8, TNEW_LOAD, 0, 3, 0, 3);
        tick();
        drive(0, 0, 0, 0, 0, 8, 3, 0, 3);
        chk("unused_stall", stall, 0);
        tick();

        // Flush in a would-stall cycle wins and empties the pipeline.
        drive(0, 0, 1, 8, TNEW_LOAD, 0, 3, 0, 3);
        tick();
        drive(0, 1, 1, 10, TNEW_ALU, 8, 1, 0, 3);
        chk("fl_stall", stall, 0);
        tick();
        chk("fl_RegWrite_E", RegWrite_E, 0);
        chk("fl_RegWrite_M", RegWrite_M, 0);
        chk("fl_RegWrite_W", RegWrite_W, 0);
        chk("fl_A3_M", A3_M, 0);
        chk("fl_Tnew_M", Tnew_M, 0);

        // Counter saturation: six stall cycles read 1,2,3,3,3,3.
        drive(1, 0, 0, 0, 0, 0, 3, 0, 3);
        tick();
        k = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 8 + i, TNEW_LOAD, 0, 3, 0, 3);
            tick();
            drive(0, 0, 0, 0, 0, 0, 3, 8 + i, 0);
            for (int j = 0; j < 2; j++) begin
                chk("sat_stall", stall, 1);
                tick();
                k++;
                chk("sat_cnt", stall_cycles, (k > CNT_MAX) ? CNT_MAX : k);
            end
            chk("sat_stall_clear", stall, 0);
            tick();
        end

        // Randomized traffic, including sporadic reset and flush.
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(1),
                  pick_reg(), $urandom_range(2), pick_reg(), $urandom_range(3),
                  pick_reg(), $urandom_range(3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
